// File: rtl/mmio_pkg.sv
// mmio_pkg: shared constants for the data-memory-port MMIO responder.
// Register map, STATUS/CTRL bit positions and default FIFO depth.
package mmio_pkg;

  localparam logic [13:0] ADDR_TXDATA = 14'h0000;
  localparam logic [13:0] ADDR_STATUS = 14'h0001;
  localparam logic [13:0] ADDR_CTRL   = 14'h0002;
  localparam logic [13:0] ADDR_DROP   = 14'h0003;
  localparam logic [13:0] ADDR_CYCLE  = 14'h0004;

  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_LVL_LSB = 8;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;

  localparam int DEF_DEPTH = 16;

  typedef struct packed {
    logic irq_en;
    logic en;
  } ctrl_t;

  function automatic logic [31:0] mk_status(
    input logic       empty,
    input logic       full,
    input logic [7:0] level
  );
    logic [31:0] s;
    s = '0;
    s[ST_EMPTY] = empty;
    s[ST_FULL]  = full;
    s[ST_LVL_LSB +: 8] = level;
    return s;
  endfunction

endpackage

// File: rtl/mmio_tx_fifo.sv
// mmio_tx_fifo: byte FIFO with level count for the MMIO transmit path.
// A push while full is accepted only when a pop happens on the same edge.
module mmio_tx_fifo
  import mmio_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          wr;
  logic          rd;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign rd    = pop & ~empty;
  assign wr    = push & (~full | rd);
  assign dout  = mem[rptr];

  // storage needs no reset; empty/level gate every use of it
  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= din;
  end

  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
      if (wr && !rd)      level <= level + 1'b1;
      else if (rd && !wr) level <= level - 1'b1;
    end
  end

endmodule

// File: rtl/dm_mmio_responder.sv
// dm_mmio_responder: SRAM-protocol peripheral on the data-memory port.
// TX byte FIFO drained by valid/ready, plus CTRL/STATUS/DROP/CYCLE.
module dm_mmio_responder
  import mmio_pkg::*;
#(
  parameter int DEPTH      = DEF_DEPTH,
  parameter int IRQ_THRESH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        CS,
  input  logic        OE,
  input  logic [3:0]  WEB,
  input  logic [13:0] A,
  input  logic [31:0] DI,
  output logic [31:0] DO,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        irq
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = AW + 1;
  localparam logic [31:0] THR = 32'(IRQ_THRESH);

  logic          wr;
  logic          rd;
  logic [3:0]    be;
  logic          hit_tx;
  logic          hit_st;
  logic          hit_ctrl;
  logic          hit_drop;
  logic          hit_cyc;
  logic          push;
  logic          pop;
  logic          drop;
  logic [LW-1:0] level;
  logic          full;
  logic          empty;
  ctrl_t         ctrl;
  logic [15:0]   drop_cnt;
  logic [31:0]   cycle;
  logic [31:0]   cyc_next;
  logic [31:0]   rdata;
  logic [31:0]   hold;

  assign be = ~WEB;
  assign wr = CS & (WEB != 4'hF);
  assign rd = CS & (WEB == 4'hF);

  assign hit_tx   = (A == ADDR_TXDATA);
  assign hit_st   = (A == ADDR_STATUS);
  assign hit_ctrl = (A == ADDR_CTRL);
  assign hit_drop = (A == ADDR_DROP);
  assign hit_cyc  = (A == ADDR_CYCLE);

  assign tx_valid = ctrl.en & ~empty;
  assign pop      = tx_valid & tx_ready;
  assign push     = wr & hit_tx & be[0];
  assign drop     = push & full & ~pop;
  assign irq      = ctrl.irq_en & (32'(level) <= THR);
  assign DO       = OE ? hold : '0;

  mmio_tx_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (push),
    .pop   (pop),
    .din   (DI[7:0]),
    .dout  (tx_data),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  // increment, then let written byte lanes override
  always_comb begin
    cyc_next = cycle + 32'd1;
    if (wr && hit_cyc) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) cyc_next[8*i +: 8] = DI[8*i +: 8];
      end
    end
  end

  // read mux over the pre-edge register values
  always_comb begin
    rdata = '0;
    unique case (1'b1)
      hit_st:   rdata = mk_status(empty, full, 8'(level));
      hit_ctrl: rdata = {30'd0, ctrl.irq_en, ctrl.en};
      hit_drop: rdata = {16'd0, drop_cnt};
      hit_cyc:  rdata = cycle;
      default:  rdata = '0;
    endcase
  end

  // control register, only byte lane 0 is implemented
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl <= '0;
    end else if (wr && hit_ctrl && be[0]) begin
      ctrl.en     <= DI[CTRL_EN];
      ctrl.irq_en <= DI[CTRL_IRQ_EN];
    end
  end

  // saturating rejected-push counter; any write clears it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt <= '0;
    end else if (wr && hit_drop) begin
      drop_cnt <= '0;
    end else if (drop && drop_cnt != 16'hFFFF) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // free-running cycle counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cycle <= '0;
    else      cycle <= cyc_next;
  end

  // read data holds until the next read access
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    hold <= '0;
    else if (rd) hold <= rdata;
  end

endmodule

// File: tb/tb_dm_mmio_responder.sv
// tb_dm_mmio_responder: directed vectors and sequences for the responder.
// Inputs change on the falling edge; outputs sampled 1 after the rising edge.
module tb_dm_mmio_responder;
  import mmio_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        CS;
  logic        OE;
  logic [3:0]  WEB;
  logic [13:0] A;
  logic [31:0] DI;
  logic [31:0] DO;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        irq;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic        cs;
    logic        oe;
    logic [3:0]  web;
    logic [13:0] a;
    logic [31:0] di;
    logic [31:0] exp_do;
    logic        exp_valid;
    logic        exp_irq;
  } vec_t;

  vec_t tv[14];

  dm_mmio_responder #(.DEPTH(16), .IRQ_THRESH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .CS       (CS),
    .OE       (OE),
    .WEB      (WEB),
    .A        (A),
    .DI       (DI),
    .DO       (DO),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus(input logic cs_i, input logic oe_i,
                     input logic [3:0] web_i, input logic [13:0] a_i,
                     input logic [31:0] di_i, input logic rdy_i);
    @(negedge clk);
    CS = cs_i; OE = oe_i; WEB = web_i; A = a_i; DI = di_i;
    tx_ready = rdy_i;
    @(posedge clk);
    #1;
    CS = 1'b0; WEB = 4'hF; tx_ready = 1'b0;
  endtask

  task automatic rd(input logic [13:0] a_i);
    bus(1'b1, 1'b1, 4'hF, a_i, 32'd0, 1'b0);
  endtask

  initial begin
    tv[0]  = '{1'b1, 1'b1, 4'hF, ADDR_STATUS, 32'h0, 32'h1, 1'b0, 1'b0};
    tv[1]  = '{1'b1, 1'b1, 4'h0, ADDR_CTRL, 32'h3, 32'h1, 1'b0, 1'b1};
    tv[2]  = '{1'b1, 1'b1, 4'hF, ADDR_CTRL, 32'h0, 32'h3, 1'b0, 1'b1};
    tv[3]  = '{1'b1, 1'b0, 4'hF, ADDR_CTRL, 32'h0, 32'h0, 1'b0, 1'b1};
    tv[4]  = '{1'b0, 1'b1, 4'hF, ADDR_CTRL, 32'h0, 32'h3, 1'b0, 1'b1};
    tv[5]  = '{1'b1, 1'b1, 4'hF, 14'h0100, 32'h0, 32'h0, 1'b0, 1'b1};
    tv[6]  = '{1'b1, 1'b1, 4'hE, ADDR_CTRL, 32'hFFFF_FF01,
               32'h0, 1'b0, 1'b0};
    tv[7]  = '{1'b1, 1'b1, 4'hF, ADDR_CTRL, 32'h0, 32'h1, 1'b0, 1'b0};
    tv[8]  = '{1'b1, 1'b1, 4'hF, ADDR_TXDATA, 32'h0, 32'h0, 1'b0, 1'b0};
    tv[9]  = '{1'b1, 1'b1, 4'hF, ADDR_DROP, 32'h0, 32'h0, 1'b0, 1'b0};
    tv[10] = '{1'b1, 1'b1, 4'h0, ADDR_CTRL, 32'h0, 32'h0, 1'b0, 1'b0};
    tv[11] = '{1'b1, 1'b1, 4'hF, ADDR_CTRL, 32'h0, 32'h0, 1'b0, 1'b0};
    tv[12] = '{1'b1, 1'b1, 4'hD, ADDR_TXDATA, 32'h99, 32'h0, 1'b0, 1'b0};
    tv[13] = '{1'b1, 1'b1, 4'hF, ADDR_STATUS, 32'h0, 32'h1, 1'b0, 1'b0};

    rst = 1'b0; CS = 1'b0; OE = 1'b1; WEB = 4'hF;
    A = '0; DI = '0; tx_ready = 1'b0;
    #12;
    chk("reset_do", DO, 32'h0);
    chk("reset_valid", {31'd0, tx_valid}, 32'h0);
    chk("reset_irq", {31'd0, irq}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 14; i++) begin
      bus(tv[i].cs, tv[i].oe, tv[i].web, tv[i].a, tv[i].di, 1'b0);
      chk($sformatf("vec%0d_do", i), DO, tv[i].exp_do);
      chk($sformatf("vec%0d_valid", i), {31'd0, tx_valid},
          {31'd0, tv[i].exp_valid});
      chk($sformatf("vec%0d_irq", i), {31'd0, irq},
          {31'd0, tv[i].exp_irq});
    end

    // two bytes streamed out with tx_ready held high
    bus(1'b1, 1'b1, 4'h0, ADDR_CTRL, 32'h3, 1'b1);
    chk("strm_ctrl_valid", {31'd0, tx_valid}, 32'h0);
    chk("strm_ctrl_irq", {31'd0, irq}, 32'h1);
    bus(1'b1, 1'b1, 4'hE, ADDR_TXDATA, 32'h41, 1'b1);
    chk("strm1_valid", {31'd0, tx_valid}, 32'h1);
    chk("strm1_data", {24'd0, tx_data}, 32'h41);
    chk("strm1_irq", {31'd0, irq}, 32'h1);
    bus(1'b1, 1'b1, 4'hE, ADDR_TXDATA, 32'h42, 1'b1);
    chk("strm2_valid", {31'd0, tx_valid}, 32'h1);
    chk("strm2_data", {24'd0, tx_data}, 32'h42);
    chk("strm2_irq", {31'd0, irq}, 32'h1);
    bus(1'b0, 1'b1, 4'hF, ADDR_TXDATA, 32'h0, 1'b1);
    chk("strm3_valid", {31'd0, tx_valid}, 32'h0);
    chk("strm3_irq", {31'd0, irq}, 32'h1);

    // fill with en=0; 17th byte is dropped
    bus(1'b1, 1'b1, 4'h0, ADDR_CTRL, 32'h0, 1'b0);
    for (int i = 0; i < 17; i++)
      bus(1'b1, 1'b1, 4'hE, ADDR_TXDATA, 32'(8'h10 + i), 1'b0);
    chk("fill_valid", {31'd0, tx_valid}, 32'h0);
    rd(ADDR_STATUS);
    chk("fill_status", DO, 32'h0000_1002);
    rd(ADDR_DROP);
    chk("fill_drop", DO, 32'h1);
    bus(1'b1, 1'b1, 4'h0, ADDR_CTRL, 32'h1, 1'b0);
    chk("en_valid", {31'd0, tx_valid}, 32'h1);
    chk("en_head", {24'd0, tx_data}, 32'h10);
    chk("en_irq", {31'd0, irq}, 32'h0);
    bus(1'b1, 1'b1, 4'hE, ADDR_TXDATA, 32'h77, 1'b1);
    chk("pushpop_head", {24'd0, tx_data}, 32'h11);
    rd(ADDR_STATUS);
    chk("pushpop_status", DO, 32'h0000_1002);
    rd(ADDR_DROP);
    chk("pushpop_drop", DO, 32'h1);
    bus(1'b1, 1'b1, 4'h7, ADDR_DROP, 32'h0, 1'b0);
    rd(ADDR_DROP);
    chk("drop_clear", DO, 32'h0);
    bus(1'b1, 1'b1, 4'hE, ADDR_TXDATA, 32'hEE, 1'b0);
    rd(ADDR_DROP);
    chk("drop_again", DO, 32'h1);

    // write lands on the edge; one idle edge, then reads show the wrap
    bus(1'b1, 1'b1, 4'h0, ADDR_CYCLE, 32'hFFFF_FFFE, 1'b0);
    bus(1'b0, 1'b1, 4'hF, ADDR_TXDATA, 32'h0, 1'b0);
    rd(ADDR_CYCLE);
    chk("cycle_ff", DO, 32'hFFFF_FFFF);
    rd(ADDR_CYCLE);
    chk("cycle_wrap", DO, 32'h0);
    bus(1'b1, 1'b1, 4'h0, ADDR_CYCLE, 32'h0000_00FF, 1'b0);
    bus(1'b1, 1'b1, 4'hE, ADDR_CYCLE, 32'hAAAA_AA55, 1'b0);
    rd(ADDR_CYCLE);
    chk("cycle_lane", DO, 32'h0000_0155);

    // drain 11 of 16 so 5 remain, then reset mid-drain
    for (int i = 0; i < 11; i++)
      bus(1'b0, 1'b1, 4'hF, ADDR_TXDATA, 32'h0, 1'b1);
    chk("drain_valid", {31'd0, tx_valid}, 32'h1);
    chk("drain_head", {24'd0, tx_data}, 32'h1C);
    tx_ready = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("rst_valid", {31'd0, tx_valid}, 32'h0);
    chk("rst_irq", {31'd0, irq}, 32'h0);
    chk("rst_do", DO, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    tx_ready = 1'b0;
    rd(ADDR_STATUS);
    chk("post_status", DO, 32'h1);
    rd(ADDR_DROP);
    chk("post_drop", DO, 32'h0);
    rd(ADDR_CTRL);
    chk("post_ctrl", DO, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_mmio_responder.md
# dm_mmio_responder

Memory-mapped peripheral responder that speaks the same CS/OE/WEB/A/DI/DO port protocol as the SRAM wrappers. The core can therefore drive it in place of, or decoded alongside, the data memory. It provides a byte transmit FIFO drained through a valid/ready stream, plus control, status, drop-count and cycle-count registers. It sits on the core's data-memory port at top level.

## Interface
- DEPTH, 16 — transmit FIFO entries (power of two, 2..256)
- IRQ_THRESH, 4 — irq condition: FIFO level ≤ this value
- clk  in  1  block clock; top connects the inverted system clock, as for the memory wrappers
- rst  in  1  reset, asynchronous, active-low
- CS  in  1  chip select; no access when 0
- OE  in  1  output enable; DO forced to 0 when 0
- WEB  in  4  byte write enables, active-low; 4'hF with CS=1 is a read
- A  in  14  word address
- DI  in  32  write data
- DO  out  32  read data
- tx_valid  out  1  FIFO head valid (CTRL.en & !empty)
- tx_ready  in  1  downstream accepts head
- tx_data  out  8  FIFO head byte
- irq  out  1  CTRL.irq_en & (level ≤ IRQ_THRESH)

## Operation
- Register map (word address):
  - 0x0000 TXDATA: write with WEB[0]=0 pushes DI[7:0]; reads 0.
  - 0x0001 STATUS, read-only: bit0 empty, bit1 full, bits[15:8] level.
  - 0x0002 CTRL, read/write byte 0 only: bit0 en, bit1 irq_en.
  - 0x0003 DROP, 16-bit saturating count of rejected pushes; any write clears it.
  - 0x0004 CYCLE, 32-bit free-running +1 per clk with wrap; write loads DI per enabled byte lane.
- Unmapped addresses: reads return 0; writes ignored.
- Access rules:
  - Access happens on a clk rising edge with CS=1.
  - Any WEB bit low makes the access a write; only low lanes update.
  - WEB=4'hF makes it a read: the register value before the edge is captured into a DO holding register.
  - DO = OE ? hold : 0. The hold register keeps its value until the next read.
- FIFO:
  - Push = TXDATA write with WEB[0]=0.
  - Pop = tx_valid & tx_ready.
  - Push while full with no pop: byte dropped, DROP++ (saturates at 16'hFFFF).
  - Push while full with a pop in the same cycle: both happen, level unchanged, no drop.
  - With en=0 the FIFO still accepts pushes; tx_valid=0.
  - Pointers wrap modulo DEPTH; level ranges 0..DEPTH.
- Reset (asynchronous, any time, including mid-transfer):
  - FIFO empties.
  - CTRL=0, DROP=0, CYCLE=0, DO hold=0.
  - Outputs: tx_valid=0, irq=0, DO=0.

## Timing
- Read latency: one edge. DO is valid after the sampling edge and stable for the full following cycle.
- Write takes effect at the sampling edge.
- STATUS read in the cycle right after a push reflects that push.
- tx_data is stable while tx_valid=1 & tx_ready=0.
- First pushed byte appears at tx_data one edge after the push, if en=1.
- tx_valid and irq are combinational from registered state. They have no path from tx_ready or the bus inputs.
- CYCLE read returns the count at the sampling edge, before that edge's increment.
- CYCLE write on the same edge overrides the increment for the written lanes; unwritten lanes still take the incremented value.

## Structure
- Package mmio_pkg holds:
  - register address localparams (ADDR_TXDATA..ADDR_CYCLE)
  - STATUS/CTRL bit-position constants
  - default DEPTH
- Sub-module mmio_tx_fifo:
  - parameterised DEPTH
  - push/pop/din/dout/level/full/empty
  - asynchronous active-low reset
- The top body holds the address decode, registers, DO hold register and irq logic.

## Test plan
- Reset, then read STATUS with OE=1 → DO=32'h0000_0001; tx_valid=0, irq=0.
- Write CTRL=3; push 0x41, 0x42; tx_ready=1 → tx_data 0x41 then 0x42 on consecutive cycles, then tx_valid=0; irq=1 throughout (level ≤ 4).
- en=0, push 17 bytes (DEPTH=16) → STATUS=32'h0000_1002, DROP=1. Same-cycle push with pop while full → no drop, level stays 16.
- Write CYCLE=32'hFFFF_FFFE with WEB=0; read twice back-to-back → DO=32'hFFFF_FFFF, then 32'h0000_0000 (wrap).
- Read unmapped 0x0100 → 0. Read with OE=0 → DO=0. Write CTRL with WEB=4'b1110, DI=32'hFFFF_FF01 → CTRL reads 1.
- Assert rst low mid-drain with 5 bytes queued → tx_valid drops immediately. After release, STATUS reads empty and DROP reads 0.
